// File: rtl/spi_reg_target_pkg.sv
// Shared types and opcodes for the SPI register-file target.
package spi_reg_target_pkg;

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR_W,
        S_ADDR_R,
        S_WDATA,
        S_RDATA,
        S_DISCARD
    } state_t;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes spi_clk and MOSI into clk and produces registered rise/fall pulses.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic spi_clk,
    input  logic serial_in,
    output logic rise,
    output logic fall,
    output logic sdata
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_sync <= '0;
            dat_sync <= '0;
            clk_prev <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            sdata    <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], serial_in};
            clk_prev <= clk_sync[SYNC_STAGES-1];
            rise     <= clk_sync[SYNC_STAGES-1] & ~clk_prev;
            fall     <= ~clk_sync[SYNC_STAGES-1] & clk_prev;
            // data is delayed one extra stage so it lines up with the rise pulse
            sdata    <= dat_sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/spi_reg_target.sv
// SPI target decoding opcode/address/data frames into register-file strobes.
// Optional write echo on MISO: define SPI_REG_TARGET_WRITE_ECHO_EN.
module spi_reg_target
    import spi_reg_target_pkg::*;
#(
    parameter int REG_WIDTH    = 8,
    parameter int IDLE_TIMEOUT = 64,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 spi_clk,
    input  logic                 serial_in,
    output logic                 serial_out,
    output logic [REG_WIDTH-1:0] reg_addr,
    output logic [REG_WIDTH-1:0] reg_wr_data,
    output logic                 reg_wr_en,
    output logic                 reg_rd_en,
    input  logic [REG_WIDTH-1:0] reg_rd_data,
    output logic                 frame_active,
    output logic                 frame_error
);

    localparam int BW = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    state_t               state, state_next;
    logic                 rise, fall, sdata;
    logic [BW-1:0]        bit_cnt;
    logic [TW-1:0]        idle_cnt;
    logic [REG_WIDTH-2:0] rx_shift;
    logic [REG_WIDTH-1:0] rx_byte;
    logic [REG_WIDTH-1:0] tx_shift;
    logic                 byte_done, timeout, err_next;
    logic                 rd_load, skip_fall, miso_en;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rstn      (rstn),
        .spi_clk   (spi_clk),
        .serial_in (serial_in),
        .rise      (rise),
        .fall      (fall),
        .sdata     (sdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_CMD;
        else       state <= state_next;
    end

    always_comb begin
        rx_byte    = {rx_shift, sdata};
        byte_done  = rise && (bit_cnt == BW'(REG_WIDTH - 1));
        // a rise in the expiry cycle keeps the frame alive
        timeout    = !rise && frame_active && (idle_cnt == TW'(IDLE_TIMEOUT - 1));
        state_next = state;
        err_next   = timeout && (bit_cnt != '0);
        if (timeout) begin
            state_next = S_CMD;
        end else if (byte_done) begin
            case (state)
                S_CMD: begin
                    if (rx_byte == REG_WIDTH'(OP_WRITE))     state_next = S_ADDR_W;
                    else if (rx_byte == REG_WIDTH'(OP_READ)) state_next = S_ADDR_R;
                    else begin
                        state_next = S_DISCARD;
                        err_next   = 1'b1;
                    end
                end
                S_ADDR_W: state_next = S_WDATA;
                S_ADDR_R: state_next = S_RDATA;
                default:  state_next = state;
            endcase
        end
    end

`ifdef SPI_REG_TARGET_WRITE_ECHO_EN
    logic echo_load;
    assign echo_load = byte_done && (state_next inside {S_ADDR_W, S_WDATA});
    assign miso_en   = state inside {S_ADDR_W, S_WDATA, S_RDATA};
`else
    assign miso_en   = (state == S_RDATA);
`endif
    assign serial_out = tx_shift[REG_WIDTH-1] & miso_en;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt      <= '0;
            idle_cnt     <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            reg_addr     <= '0;
            reg_wr_data  <= '0;
            reg_wr_en    <= 1'b0;
            reg_rd_en    <= 1'b0;
            rd_load      <= 1'b0;
            skip_fall    <= 1'b0;
            frame_active <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            rd_load     <= reg_rd_en;
            frame_error <= err_next;

            if (rise) begin
                rx_shift     <= rx_byte[REG_WIDTH-2:0];
                idle_cnt     <= '0;
                frame_active <= 1'b1;
                bit_cnt      <= byte_done ? '0 : bit_cnt + BW'(1);
            end else if (idle_cnt != TW'(IDLE_TIMEOUT)) begin
                idle_cnt <= idle_cnt + TW'(1);
            end

            if (byte_done) begin
                case (state)
                    S_ADDR_W: reg_addr <= rx_byte;
                    S_ADDR_R: begin
                        reg_addr  <= rx_byte;
                        reg_rd_en <= 1'b1;
                    end
                    S_WDATA: begin
                        reg_wr_data <= rx_byte;
                        reg_wr_en   <= 1'b1;
                    end
                    S_RDATA: begin
                        reg_addr  <= reg_addr + REG_WIDTH'(1);
                        reg_rd_en <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (reg_wr_en) reg_addr <= reg_addr + REG_WIDTH'(1);

            // a fresh load lands before the byte's last fall, so that fall must not shift
            if (rd_load) begin
                tx_shift  <= reg_rd_data;
                skip_fall <= 1'b1;
`ifdef SPI_REG_TARGET_WRITE_ECHO_EN
            end else if (echo_load) begin
                tx_shift  <= rx_byte;
                skip_fall <= 1'b1;
`endif
            end else if (fall) begin
                if (skip_fall) skip_fall <= 1'b0;
                else           tx_shift  <= {tx_shift[REG_WIDTH-2:0], 1'b0};
            end

            if (timeout) begin
                frame_active <= 1'b0;
                bit_cnt      <= '0;
                tx_shift     <= '0;
                skip_fall    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_target.sv
// Bench for spi_reg_target: table vectors, corner sequences and random frames vs a frame-level model.
module tb_spi_reg_target;

    localparam int TO = 64;
    localparam int HP = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       spi_clk = 1'b0;
    logic       serial_in = 1'b0;
    logic       serial_out;
    logic [7:0] reg_addr, reg_wr_data, reg_rd_data;
    logic       reg_wr_en, reg_rd_en, frame_active, frame_error;

    always #5 clk = ~clk;

    spi_reg_target #(.REG_WIDTH(8), .IDLE_TIMEOUT(TO), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .spi_clk      (spi_clk),
        .serial_in    (serial_in),
        .serial_out   (serial_out),
        .reg_addr     (reg_addr),
        .reg_wr_data  (reg_wr_data),
        .reg_wr_en    (reg_wr_en),
        .reg_rd_en    (reg_rd_en),
        .reg_rd_data  (reg_rd_data),
        .frame_active (frame_active),
        .frame_error  (frame_error)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] init_val(int i);
        if (i == 32'h20) return 8'h3C;
        if (i == 32'h21) return 8'hC3;
        return 8'(i * 7 + 3);
    endfunction

    // register file emulation
    logic [7:0] mem [256];
    bit         init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            reg_rd_data <= 8'h00;
            init_done   <= 1'b1;
        end else begin
            if (reg_wr_en) mem[reg_addr] <= reg_wr_data;
            if (reg_rd_en) reg_rd_data <= mem[reg_addr];
        end
    end

    logic [15:0] wr_log [$];
    logic [7:0]  rd_log [$];
    int          err_pulses = 0;
    int          both_hi = 0;
    always @(negedge clk) begin
        if (reg_wr_en) wr_log.push_back({reg_addr, reg_wr_data});
        if (reg_rd_en) rd_log.push_back(reg_addr);
        if (frame_error) err_pulses++;
        if (reg_wr_en && reg_rd_en) both_hi++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic r);
        serial_in = b;
        repeat (HP) @(negedge clk);
        r = serial_out;
        spi_clk = 1'b1;
        repeat (HP) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            logic r;
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic idle(input int n);
        serial_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] tx [$], output logic [7:0] rx [$]);
        rx = {};
        foreach (tx[i]) begin
            logic [7:0] r;
            spi_byte(tx[i], r);
            rx.push_back(r);
        end
        idle(TO + 10);
    endtask

    // frame-level reference: what a whole frame must do, from the protocol rules
    logic [7:0] ref_mem [256];
    task automatic model(input logic [7:0] tx [$], output logic [15:0] ewr [$],
                         output logic [7:0] erd [$], output logic [7:0] emiso [$], output int eerr);
        int n;
        n = tx.size();
        ewr = {}; erd = {}; emiso = {}; eerr = 0;
        for (int k = 0; k < n; k++) emiso.push_back(8'h00);
        if (tx[0] == 8'h01) begin
            for (int k = 2; k < n; k++) begin
                logic [7:0] a;
                a = tx[1] + 8'(k - 2);
                ewr.push_back({a, tx[k]});
                ref_mem[a] = tx[k];
            end
`ifdef SPI_REG_TARGET_WRITE_ECHO_EN
            for (int k = 1; k < n; k++) emiso[k] = tx[k-1];
`endif
        end else if (tx[0] == 8'h02) begin
            for (int k = 1; k < n; k++) erd.push_back(tx[1] + 8'(k - 1));
            for (int k = 2; k < n; k++) emiso[k] = ref_mem[8'(tx[1] + 8'(k - 2))];
        end else begin
            eerr = 1;
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] tx [$]);
        logic [7:0]  rx [$];
        logic [15:0] ewr [$];
        logic [7:0]  erd [$];
        logic [7:0]  emiso [$];
        int eerr, wb, rb, eb;
        wb = wr_log.size(); rb = rd_log.size(); eb = err_pulses;
        model(tx, ewr, erd, emiso, eerr);
        run_frame(tx, rx);
        check({tag, ".nwr"}, wr_log.size() - wb, ewr.size());
        foreach (ewr[k]) if (wb + k < wr_log.size()) check({tag, ".wr"}, wr_log[wb+k], ewr[k]);
        check({tag, ".nrd"}, rd_log.size() - rb, erd.size());
        foreach (erd[k]) if (rb + k < rd_log.size()) check({tag, ".rd"}, rd_log[rb+k], erd[k]);
        foreach (emiso[k]) check({tag, ".miso"}, rx[k], emiso[k]);
        check({tag, ".err"}, err_pulses - eb, eerr);
        check({tag, ".active"}, frame_active, 0);
    endtask

    typedef struct {
        logic [7:0]  tx   [4];
        int          nwr;
        logic [15:0] wr   [2];
        int          nrd;
        logic [7:0]  rd   [3];
        int          nerr;
        logic [7:0]  miso [4];
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [7:0]  txq [$];
        logic [7:0]  rxq [$];
        logic [15:0] dwr [$];
        logic [7:0]  drd [$];
        logic [7:0]  dmi [$];
        int          derr, wb, rb, eb;
        logic        dummy;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        vecs[0] = '{tx: '{8'h01, 8'h10, 8'hAA, 8'h55}, nwr: 2, wr: '{16'h10AA, 16'h1155},
                    nrd: 0, rd: '{8'h00, 8'h00, 8'h00}, nerr: 0, miso: '{8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[1] = '{tx: '{8'h02, 8'h20, 8'h00, 8'h00}, nwr: 0, wr: '{16'h0, 16'h0},
                    nrd: 3, rd: '{8'h20, 8'h21, 8'h22}, nerr: 0, miso: '{8'h00, 8'h00, 8'h3C, 8'hC3}};
        vecs[2] = '{tx: '{8'h01, 8'hFF, 8'h11, 8'h22}, nwr: 2, wr: '{16'hFF11, 16'h0022},
                    nrd: 0, rd: '{8'h00, 8'h00, 8'h00}, nerr: 0, miso: '{8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[3] = '{tx: '{8'h7E, 8'h01, 8'h02, 8'h03}, nwr: 0, wr: '{16'h0, 16'h0},
                    nrd: 0, rd: '{8'h00, 8'h00, 8'h00}, nerr: 1, miso: '{8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[4] = '{tx: '{8'h02, 8'hFF, 8'h00, 8'h00}, nwr: 0, wr: '{16'h0, 16'h0},
                    nrd: 3, rd: '{8'hFF, 8'h00, 8'h01}, nerr: 0, miso: '{8'h00, 8'h00, 8'h11, 8'h22}};
`ifdef SPI_REG_TARGET_WRITE_ECHO_EN
        vecs[0].miso = '{8'h00, 8'h01, 8'h10, 8'hAA};
        vecs[2].miso = '{8'h00, 8'h01, 8'hFF, 8'h11};
`endif

        // reset state
        repeat (3) @(negedge clk);
        check("rst.serial_out", serial_out, 0);
        check("rst.reg_addr", reg_addr, 0);
        check("rst.reg_wr_data", reg_wr_data, 0);
        check("rst.reg_wr_en", reg_wr_en, 0);
        check("rst.reg_rd_en", reg_rd_en, 0);
        check("rst.frame_active", frame_active, 0);
        check("rst.frame_error", frame_error, 0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            txq = {};
            for (int k = 0; k < 4; k++) txq.push_back(vecs[v].tx[k]);
            wb = wr_log.size(); rb = rd_log.size(); eb = err_pulses;
            model(txq, dwr, drd, dmi, derr);
            run_frame(txq, rxq);
            check($sformatf("vec%0d.nwr", v), wr_log.size() - wb, vecs[v].nwr);
            for (int k = 0; k < vecs[v].nwr; k++)
                if (wb + k < wr_log.size()) check($sformatf("vec%0d.wr%0d", v, k), wr_log[wb+k], vecs[v].wr[k]);
            check($sformatf("vec%0d.nrd", v), rd_log.size() - rb, vecs[v].nrd);
            for (int k = 0; k < vecs[v].nrd; k++)
                if (rb + k < rd_log.size()) check($sformatf("vec%0d.rd%0d", v, k), rd_log[rb+k], vecs[v].rd[k]);
            check($sformatf("vec%0d.err", v), err_pulses - eb, vecs[v].nerr);
            for (int k = 0; k < 4; k++) check($sformatf("vec%0d.miso%0d", v, k), rxq[k], vecs[v].miso[k]);
        end

        // partial byte then idle: error pulse, no strobe, frame ends
        wb = wr_log.size(); eb = err_pulses;
        for (int i = 0; i < 5; i++) spi_bit(1'b1, dummy);
        check("partial.active_mid", frame_active, 1);
        idle(TO + 4);
        check("partial.err", err_pulses - eb, 1);
        check("partial.active", frame_active, 0);
        check("partial.nwr", wr_log.size() - wb, 0);
        check_frame("after_partial", '{8'h01, 8'h05, 8'h99});

        // reset in the middle of a write data byte
        wb = wr_log.size();
        begin
            logic [7:0] r;
            spi_byte(8'h01, r);
            spi_byte(8'h10, r);
        end
        for (int i = 0; i < 4; i++) spi_bit(1'b1, dummy);
        rstn = 1'b0;
        #1;
        check("midrst.reg_addr", reg_addr, 0);
        check("midrst.wr_en", reg_wr_en, 0);
        check("midrst.rd_en", reg_rd_en, 0);
        check("midrst.active", frame_active, 0);
        check("midrst.serial_out", serial_out, 0);
        check("midrst.wr_data", reg_wr_data, 0);
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        idle(TO + 10);
        check("midrst.nwr", wr_log.size() - wb, 0);
        check_frame("after_rst", '{8'h02, 8'h05, 8'h00});
        check_frame("echo_short", '{8'h01, 8'h10, 8'hAA});

        // random frames against the model
        for (int f = 0; f < 30; f++) begin
            int sel, n;
            sel = $urandom_range(0, 9);
            n   = $urandom_range(1, 5);
            txq = {};
            if (sel < 4)      txq.push_back(8'h01);
            else if (sel < 8) txq.push_back(8'h02);
            else              txq.push_back(8'h80 | 8'($urandom));
            for (int k = 1; k < n; k++) txq.push_back(8'($urandom));
            check_frame($sformatf("rnd%0d", f), txq);
        end

        check("wr_rd_exclusive", both_hi, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_target.md
Name: spi_reg_target

Overview:
- SPI target (peripheral) end of the link driven by the board's SPI master; on-chip register-file front end used for loopback and emulation of the front-end ASIC.
- Oversamples spi_clk and MOSI in the system clock domain and decodes frames of opcode byte, start address byte, then data bytes.
- Issues single-cycle register-file write/read strobes with auto-incrementing address; shifts read data back on MISO.

Parameters:
- REG_WIDTH, 8, width of address, data and each SPI byte.
- IDLE_TIMEOUT, 64, clk cycles with no spi_clk rising edge that end the current frame.
- SYNC_STAGES, 2, synchronizer depth on spi_clk and serial_in (minimum 2).

Ports:
- clk  in  1  system clock; spi_clk must be at most clk/8.
- rstn  in  1  asynchronous active-low reset.
- spi_clk  in  1  SPI clock from master, idle low.
- serial_in  in  1  MOSI.
- serial_out  out  1  MISO.
- reg_addr  out  REG_WIDTH  register-file address.
- reg_wr_data  out  REG_WIDTH  write data.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rd_data  in  REG_WIDTH  read data, valid exactly 1 clk after reg_rd_en.
- frame_active  out  1  high from the first spi_clk rising edge until timeout.
- frame_error  out  1  one-cycle pulse on an illegal opcode or a timeout with a partial byte.

Behaviour:
- Reset: async on rstn low. All outputs 0, state S_CMD, bit counter 0, timeout counter 0, shift registers 0. Reset mid-frame aborts the frame with no strobe.
- Sync: SYNC_STAGES flops on spi_clk and serial_in, then edge detect. Rise and fall pulses appear SYNC_STAGES+1 clk after the pin edge.
- Sampling and bit order:
  - MOSI sampled on rise, MSB first.
  - The bit counter wraps at REG_WIDTH; its wrap is the byte_done event.
  - MISO shift register advances on fall. serial_out is the shift-register MSB.
- States (transitions on byte_done unless noted):
  - S_CMD: byte 8'h01 goes to S_ADDR_W; 8'h02 goes to S_ADDR_R; any other value pulses frame_error and goes to S_DISCARD.
  - S_ADDR_W: latch reg_addr, go to S_WDATA.
  - S_ADDR_R: latch reg_addr and pulse reg_rd_en next cycle. The cycle after that, load reg_rd_data into the MISO shift register so its MSB is on serial_out before the following rise. Go to S_RDATA.
  - S_WDATA: each byte_done drives reg_wr_data = byte and pulses reg_wr_en for one cycle with the current reg_addr. reg_addr increments the cycle after the strobe.
  - S_RDATA: each byte_done increments reg_addr, pulses reg_rd_en, and loads the returned data one cycle later. The read is prefetched; a master that stops early is harmless.
  - S_DISCARD: bytes are ignored, serial_out is 0, there are no strobes.
- Address arithmetic is modulo 2^REG_WIDTH (8'hFF wraps to 8'h00). No bound on frame length.
- MISO outside S_RDATA is 0 (but see the optional feature).
- Timeout:
  - The timeout counter clears on every rise and saturates at IDLE_TIMEOUT.
  - On reaching IDLE_TIMEOUT: state goes to S_CMD, bit counter clears, frame_active drops, serial_out goes to 0.
  - If the bit counter was nonzero at that point, frame_error pulses and the partial byte is dropped (no strobe).
- Simultaneous events: a rise in the same cycle as the timeout expiry wins; the counter clears and no timeout occurs. reg_wr_en and reg_rd_en are never high together.

Optional Feature:
- Macro SPI_REG_TARGET_WRITE_ECHO_EN.
- Defined: during S_ADDR_W and S_WDATA, the MISO shift register is loaded at each byte_done with the byte just received. The master's read-during-write data is then the previous byte (opcode, then address, then data).
- Undefined: MISO is 0 during write frames. No echo logic is synthesized.

Decomposition:
- Package spi_reg_target_pkg holds:
  - state enum: S_CMD, S_ADDR_W, S_ADDR_R, S_WDATA, S_RDATA, S_DISCARD;
  - OP_WRITE = 8'h01 and OP_READ = 8'h02.
- Sub-module spi_edge_sync: the synchronizer chain plus rise/fall pulse generation, with synced serial_in, one instance per link.

Test Plan:
- Write frame 01,10,AA,55 -> reg_wr_en twice: addr 10 data AA, then addr 11 data 55. No frame_error.
- Register model preloaded 20=3C, 21=C3; read frame 02,20 then 2 dummy bytes -> MISO bytes 3C, C3; reg_rd_en pulses for addr 20, 21, 22.
- Write starting at FF with 2 data bytes -> writes at FF, then 00.
- Opcode 7E followed by 3 bytes -> frame_error pulses once, no strobes, MISO stays 0.
- 5 bits sent, then IDLE_TIMEOUT+1 idle cycles -> frame_error pulse, frame_active low. The next frame 01,05,99 writes 99 at 05.
- rstn low mid-data-byte of a write frame -> all outputs 0 immediately, no reg_wr_en. With ECHO_EN defined, frame 01,10,AA gives MISO 00,01,10.
